// File: rtl/vram_wr_arbiter.sv
// VRAM write-port owner: full-memory clear after reset or on request, then a
// two-way round-robin arbiter (valid/ready) feeding the single write port.

package ili9341_pkg;

    // RGB565 pixel as stored in VRAM
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } ILI9341_color_t;

    localparam ILI9341_color_t BLACK = '0;
    localparam ILI9341_color_t RED   = '{r: 5'h1f, g: 6'h00, b: 5'h00};

endpackage

module vram_wr_arbiter #(
    parameter int unsigned                 L          = 32,
    parameter ili9341_pkg::ILI9341_color_t VRAM_CLEAR = ili9341_pkg::BLACK,
    localparam int unsigned                AW         = (L > 1) ? $clog2(L) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_req,
    input  logic                        req0_valid,
    input  logic [AW-1:0]               req0_addr,
    input  ili9341_pkg::ILI9341_color_t req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [AW-1:0]               req1_addr,
    input  ili9341_pkg::ILI9341_color_t req1_data,
    output logic                        req1_ready,
    output logic                        vram_wr_ena,
    output logic [AW-1:0]               vram_wr_addr,
    output ili9341_pkg::ILI9341_color_t vram_wr_data,
    output logic                        draw_ena,
    output logic                        clear_done,
    output logic                        wr_oob
);

    localparam int unsigned   CW         = AW + 1;
    localparam logic [CW-1:0] LAST_ADDR  = CW'(L - 1);
    localparam logic [CW-1:0] ADDR_LIMIT = CW'(L);

    localparam logic [0:0] S_CLEARING = 1'b0;
    localparam logic [0:0] S_ACTIVE   = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rr, rr_nxt;
    logic          clear_done_q, clear_done_nxt;

    logic                        grant_vld;
    logic                        grant_sel;
    logic [AW-1:0]               sel_addr;
    ili9341_pkg::ILI9341_color_t sel_data;
    logic                        sel_oob;

    // State, clear counter, round-robin pointer and clear-done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_CLEARING;
            cnt          <= '0;
            rr           <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rr           <= rr_nxt;
            clear_done_q <= clear_done_nxt;
        end
    end

    // Next state plus zero-latency write-port and handshake outputs
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        rr_nxt         = rr;
        clear_done_nxt = 1'b0;
        grant_vld      = 1'b0;
        grant_sel      = 1'b0;
        sel_addr       = '0;
        sel_data       = '0;
        sel_oob        = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        vram_wr_ena    = 1'b0;
        vram_wr_addr   = '0;
        vram_wr_data   = '0;
        draw_ena       = 1'b0;
        wr_oob         = 1'b0;

        // A reset cycle drops everything, including a pending grant
        if (!rst) begin
            case (state)
                S_CLEARING: begin
                    vram_wr_ena  = 1'b1;
                    vram_wr_addr = cnt[AW-1:0];
                    vram_wr_data = VRAM_CLEAR;
                    if (cnt == LAST_ADDR) begin
                        state_nxt      = S_ACTIVE;
                        cnt_nxt        = '0;
                        clear_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end

                S_ACTIVE: begin
                    draw_ena = 1'b1;
                    if (clear_req) begin
                        state_nxt = S_CLEARING;
                        cnt_nxt   = '0;
                    end else begin
                        // Contention alternates; a lone requester keeps rr
                        if (req0_valid && req1_valid) begin
                            grant_vld = 1'b1;
                            grant_sel = rr;
                            rr_nxt    = ~rr;
                        end else if (req0_valid) begin
                            grant_vld = 1'b1;
                            grant_sel = 1'b0;
                        end else if (req1_valid) begin
                            grant_vld = 1'b1;
                            grant_sel = 1'b1;
                        end

                        if (grant_vld) begin
                            sel_addr     = grant_sel ? req1_addr : req0_addr;
                            sel_data     = grant_sel ? req1_data : req0_data;
                            sel_oob      = ({1'b0, sel_addr} >= ADDR_LIMIT);
                            req0_ready   = ~grant_sel;
                            req1_ready   = grant_sel;
                            vram_wr_ena  = ~sel_oob;
                            wr_oob       = sel_oob;
                            vram_wr_addr = sel_addr;
                            vram_wr_data = sel_data;
                        end
                    end
                end

                default: begin
                    state_nxt = S_CLEARING;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Registered pulse, forced low while reset is asserted
    always_comb begin
        clear_done = clear_done_q & ~rst;
    end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Bench: two arbiters (L=32 and L=20) driven by identical stimulus and checked
// every cycle against a per-instance cycle model built from the behaviour rules.

module tb_vram_wr_arbiter;

    import ili9341_pkg::*;

    localparam int unsigned AW = 5;

    logic           clk;
    logic           rst;
    logic           clear_req;
    logic           req0_valid;
    logic [AW-1:0]  req0_addr;
    ILI9341_color_t req0_data;
    logic           req1_valid;
    logic [AW-1:0]  req1_addr;
    ILI9341_color_t req1_data;

    logic           rdy0_o [2];
    logic           rdy1_o [2];
    logic           ena_o  [2];
    logic [AW-1:0]  addr_o [2];
    ILI9341_color_t data_o [2];
    logic           draw_o [2];
    logic           done_o [2];
    logic           oob_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: clr_idx = next clear address, or -1 when active
    int lim     [2] = '{32, 20};
    int clr_idx [2];
    int rr_m    [2];
    int done_m  [2];

    vram_wr_arbiter #(.L(32), .VRAM_CLEAR(BLACK)) u_l32 (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0_o[0]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1_o[0]),
        .vram_wr_ena(ena_o[0]), .vram_wr_addr(addr_o[0]), .vram_wr_data(data_o[0]),
        .draw_ena(draw_o[0]), .clear_done(done_o[0]), .wr_oob(oob_o[0])
    );

    vram_wr_arbiter #(.L(20), .VRAM_CLEAR(BLACK)) u_l20 (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0_o[1]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1_o[1]),
        .vram_wr_ena(ena_o[1]), .vram_wr_addr(addr_o[1]), .vram_wr_data(data_o[1]),
        .draw_ena(draw_o[1]), .clear_done(done_o[1]), .wr_oob(oob_o[1])
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Predict one cycle for instance k, compare, then advance the model
    task automatic model_cycle(input int k);
        int e_ena, e_r0, e_r1, e_draw, e_done, e_oob, e_addr, e_data;
        int g, a, d;
        bit chk_ad;
        e_ena = 0; e_r0 = 0; e_r1 = 0; e_draw = 0; e_done = 0; e_oob = 0;
        e_addr = 0; e_data = 0; chk_ad = 1'b0;

        if (rst) begin
            clr_idx[k] = 0;
            rr_m[k]    = 0;
            done_m[k]  = 0;
        end else if (clr_idx[k] >= 0) begin
            e_ena  = 1;
            e_addr = clr_idx[k];
            e_data = 0;
            chk_ad = 1'b1;
            e_done = done_m[k];
            if (clr_idx[k] == lim[k] - 1) begin
                clr_idx[k] = -1;
                done_m[k]  = 1;
            end else begin
                clr_idx[k] = clr_idx[k] + 1;
                done_m[k]  = 0;
            end
        end else begin
            e_draw    = 1;
            e_done    = done_m[k];
            done_m[k] = 0;
            if (clear_req) begin
                clr_idx[k] = 0;
            end else begin
                g = -1;
                if (req0_valid && req1_valid) begin
                    g       = rr_m[k];
                    rr_m[k] = 1 - rr_m[k];
                end else if (req0_valid) begin
                    g = 0;
                end else if (req1_valid) begin
                    g = 1;
                end
                if (g < 0) begin
                    chk_ad = 1'b1;
                end else begin
                    a     = (g == 1) ? int'(req1_addr) : int'(req0_addr);
                    d     = (g == 1) ? int'(req1_data) : int'(req0_data);
                    e_r0  = (g == 0) ? 1 : 0;
                    e_r1  = (g == 1) ? 1 : 0;
                    e_oob = (a >= lim[k]) ? 1 : 0;
                    e_ena = 1 - e_oob;
                    if (e_oob == 0) begin
                        chk_ad = 1'b1;
                        e_addr = a;
                        e_data = d;
                    end
                end
            end
        end

        check($sformatf("L%0d.vram_wr_ena", lim[k]), int'(ena_o[k]),  e_ena);
        check($sformatf("L%0d.req0_ready",  lim[k]), int'(rdy0_o[k]), e_r0);
        check($sformatf("L%0d.req1_ready",  lim[k]), int'(rdy1_o[k]), e_r1);
        check($sformatf("L%0d.draw_ena",    lim[k]), int'(draw_o[k]), e_draw);
        check($sformatf("L%0d.clear_done",  lim[k]), int'(done_o[k]), e_done);
        check($sformatf("L%0d.wr_oob",      lim[k]), int'(oob_o[k]),  e_oob);
        if (chk_ad) begin
            check($sformatf("L%0d.vram_wr_addr", lim[k]), int'(addr_o[k]), e_addr);
            check($sformatf("L%0d.vram_wr_data", lim[k]), int'(data_o[k]), e_data);
        end
    endtask

    // Drive one cycle of inputs, check both instances at the falling edge
    task automatic cyc(input bit r, input bit c,
                       input bit v0, input int a0, input int d0,
                       input bit v1, input int a1, input int d1);
        rst        = r;
        clear_req  = c;
        req0_valid = v0;
        req0_addr  = AW'(a0);
        req0_data  = ILI9341_color_t'(16'(d0));
        req1_valid = v1;
        req1_addr  = AW'(a1);
        req1_data  = ILI9341_color_t'(16'(d1));
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        clear_req  = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = BLACK;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = BLACK;
        for (int k = 0; k < 2; k++) begin
            clr_idx[k] = 0;
            rr_m[k]    = 0;
            done_m[k]  = 0;
        end
        @(posedge clk);
        #1;

        // Reset, then a draw request waiting through the post-reset clear
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (40) cyc(0, 0, 1, 5, 16'hF800, 0, 0, 0);

        // Continuous contention: grants alternate
        repeat (10) cyc(0, 0, 1, 1, 16'h1234, 1, 2, 16'h5678);

        // Clear request collides with a host write, host waits out the clear
        cyc(0, 1, 0, 0, 0, 1, 7, 16'h07E0);
        repeat (40) cyc(0, 0, 0, 0, 0, 1, 7, 16'h07E0);

        // Addresses straddling the L=20 limit
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, (i % 2 == 0) ? 25 : 19, 16'hABCD, 0, 0, 0);
        end

        // Reset in the middle of a clear, which then restarts from zero
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 3, 16'h0001, 1, 4, 16'h0002);
        repeat (40) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 400) == 0, ($urandom % 80) == 0,
                1'($urandom), int'($urandom % 32), int'($urandom % 65536),
                1'($urandom), int'($urandom % 32), int'($urandom % 65536));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_wr_arbiter.md
Name: vram_wr_arbiter

Overview:
Owns the single VRAM write port. After reset, and on request, it runs a full-memory clear sequence. Outside of clearing, it shares the port between two requesters using round-robin arbitration with a valid/ready handshake. It sits between the drawing logic (cursor/pen, host/UART writer) and the dual-port VRAM write side, and it tells the drawing logic when drawing is allowed.

Parameters:
L, 32, number of VRAM words; address width AW = $clog2(L).
VRAM_CLEAR, BLACK, ILI9341_color_t value written during a clear.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
clear_req  input  1  one-cycle pulse; requests a full VRAM clear.
req0_valid  input  1  requester 0 (draw) has a write pending.
req0_addr  input  AW  requester 0 write address.
req0_data  input  ILI9341_color_t  requester 0 write colour.
req0_ready  output  1  requester 0 write accepted this cycle.
req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for requester 1 (host).
vram_wr_ena  output  1  VRAM write strobe.
vram_wr_addr  output  AW  VRAM write address.
vram_wr_data  output  ILI9341_color_t  VRAM write colour.
draw_ena  output  1  high when VRAM is not being cleared.
clear_done  output  1  one-cycle pulse on the first ACTIVE cycle after a clear.
wr_oob  output  1  one-cycle pulse when an accepted write has addr >= L.

Behaviour:
- States: S_CLEARING, S_ACTIVE. Registered state, clear counter (AW+1 bits), round-robin pointer rr (0 or 1).
- On rst: state=S_CLEARING, counter=0, rr=0. Outputs during the reset cycle: vram_wr_ena=0, req*_ready=0, draw_ena=0, clear_done=0, wr_oob=0.
- S_CLEARING:
  - Each cycle: vram_wr_ena=1, vram_wr_addr=counter, vram_wr_data=VRAM_CLEAR, then counter++.
  - After the write to L-1, go to S_ACTIVE. Exactly L write cycles, addresses 0..L-1 in order, no gaps.
  - req*_ready=0 and draw_ena=0 throughout. clear_req is ignored.
- S_ACTIVE:
  - draw_ena=1.
  - Write-port outputs are combinational from state, rr and requester inputs. Zero latency: the write happens in the same cycle valid&ready is seen.
  - Grant rules:
    - Only one valid: grant it.
    - Both valid: grant req[rr]; on that grant, rr <= ~rr.
    - Single-requester grants leave rr unchanged.
  - Granted requester: ready=1; vram_wr_addr/data = its addr/data; vram_wr_ena=1. The non-granted ready=0.
  - Neither valid: vram_wr_ena=0; addr/data are don't-care but must be stable (hold 0).
  - Out-of-range (addr >= L, possible when L is not a power of 2): write is still accepted (ready=1), but vram_wr_ena=0 and wr_oob=1 for that cycle. rr updates as for a normal grant.
  - clear_req=1: takes priority over requesters. That cycle req*_ready=0 and vram_wr_ena=0. Next cycle state=S_CLEARING, counter=0.
- clear_done: registered; high exactly the first cycle state==S_ACTIVE after any clear, including the post-reset clear.
- Reset mid-clear: the clear restarts from address 0. rst mid-handshake drops the pending grant; no write is issued that cycle.
- Requesters must hold valid/addr/data stable until ready. The arbiter never issues two writes in one cycle.

Test Plan:
- Reset, L=32: release rst at cycle 0 -> cycles 0..31 vram_wr_ena=1, addr 0..31, data BLACK. Cycle 32: draw_ena=1, clear_done=1. Cycle 33: clear_done=0.
- req0_valid during clearing (addr 5, RED) -> req0_ready=0 until first ACTIVE cycle, then a single write: addr 5, RED, ready=1.
- Both valid continuously in ACTIVE (req0 addr 1, req1 addr 2) -> grants alternate 0,1,0,1 from rr=0; one vram_wr_ena per cycle.
- clear_req with req1_valid in the same ACTIVE cycle -> no write and req1_ready=0 that cycle. Next 32 cycles clear 0..31. req1 is granted in the first cycle after clear_done... i.e., the cycle clear_done=1.
- L=20, req0 addr 25 -> req0_ready=1, vram_wr_ena=0, wr_oob=1 for one cycle. addr 19 -> normal write.
- rst asserted at clear address 10 -> the next clear sequence restarts at address 0 and runs 0..L-1.
